// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the MEM-stage load/store unit.
// slave: the load/store unit itself. master: execute stage, writeback and data_memory side.
interface load_store_unit_if #(
  parameter int unsigned depth_p = 1024
);
  localparam int unsigned aw = $clog2(depth_p * 4);

  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_wdata_i;
  logic [4:0]    req_rd_i;

  logic          resp_valid_o;
  logic [31:0]   resp_data_o;
  logic [4:0]    resp_rd_o;
  logic          store_done_o;
  logic          misalign_o;
  logic [31:0]   misalign_addr_o;

  logic [aw-1:0] mem_addr_o;
  logic          mem_re_o;
  logic          mem_we_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_wmask_o;
  logic [31:0]   mem_rdata_i;
  logic          mem_busy_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    input  mem_rdata_i, mem_busy_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, store_done_o, misalign_o,
    output misalign_addr_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, mem_wmask_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    output mem_rdata_i, mem_busy_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, store_done_o, misalign_o,
    input  misalign_addr_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, mem_wmask_o
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one request at a time, drives data_memory with
// byte address/mask/replicated data, waits out partial-store RMW, extends loads.
module load_store_unit #(
  parameter int unsigned depth_p = 1024
) (
  input logic              clk_i,
  input logic              reset_i,
  load_store_unit_if.slave bus
);
  localparam int unsigned aw = $clog2(depth_p * 4);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_e;

  state_e        r_state, w_state_nxt;
  logic          w_accept, w_misalign;
  logic [1:0]    w_off;
  logic [31:0]   w_wdata;
  logic [3:0]    w_mask;
  logic [31:0]   w_shifted, w_load_ext;

  logic [aw-1:0] w_mem_addr;
  logic          w_mem_re, w_mem_we;
  logic [31:0]   w_mem_wdata;
  logic [3:0]    w_mem_wmask;

  logic [aw-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_mask;
  logic [1:0]    r_off, r_size;
  logic          r_unsigned;
  logic [4:0]    r_ld_rd;
  logic          r_resp_valid, r_store_done, r_misalign;
  logic [31:0]   r_resp_data, r_misalign_addr;
  logic [4:0]    r_resp_rd;

  // Gating with reset keeps every memory output at zero while reset is held.
  assign w_accept = bus.req_valid_i && (r_state == IDLE) && !reset_i;
  assign w_off    = bus.req_addr_i[1:0];

  // Decode request size into lane-replicated data, byte mask and alignment fault
  always_comb begin
    w_misalign = 1'b0;
    w_wdata    = bus.req_wdata_i;
    w_mask     = 4'hF;
    case (bus.req_size_i)
      2'b00: begin
        w_wdata = {4{bus.req_wdata_i[7:0]}};
        w_mask  = 4'b0001 << w_off;
      end
      2'b01: begin
        w_wdata    = {2{bus.req_wdata_i[15:0]}};
        w_mask     = 4'b0011 << w_off;
        w_misalign = w_off[0];
      end
      2'b10:   w_misalign = (w_off != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    w_shifted = bus.mem_rdata_i >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_load_ext = r_unsigned ? {24'h0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_ext = r_unsigned ? {16'h0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_ext = bus.mem_rdata_i;
    endcase
  end

  // Next state and memory drive: live request in the accept cycle, registered copy otherwise
  always_comb begin
    w_state_nxt = r_state;
    w_mem_addr  = r_addr;
    w_mem_wdata = r_wdata;
    w_mem_wmask = r_mask;
    w_mem_re    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_mem_addr  = bus.req_addr_i[aw-1:0];
          w_mem_wdata = w_wdata;
          w_mem_wmask = w_mask;
          if (!w_misalign) begin
            if (bus.req_we_i) begin
              w_mem_we = 1'b1;
              if (bus.mem_busy_i) w_state_nxt = STORE_WAIT;
            end else begin
              w_mem_re    = 1'b1;
              w_state_nxt = LOAD_WAIT;
            end
          end
        end
      end
      LOAD_WAIT:  w_state_nxt = IDLE;
      STORE_WAIT: if (!bus.mem_busy_i) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Request copies and single-cycle result pulses
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_addr          <= '0;
      r_wdata         <= '0;
      r_mask          <= '0;
      r_off           <= '0;
      r_size          <= '0;
      r_unsigned      <= 1'b0;
      r_ld_rd         <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_rd       <= '0;
      r_store_done    <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_store_done <= 1'b0;
      r_misalign   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr     <= bus.req_addr_i[aw-1:0];
            r_wdata    <= w_wdata;
            r_mask     <= w_mask;
            r_off      <= w_off;
            r_size     <= bus.req_size_i;
            r_unsigned <= bus.req_unsigned_i;
            r_ld_rd    <= bus.req_rd_i;
            if (w_misalign) begin
              r_misalign      <= 1'b1;
              r_misalign_addr <= bus.req_addr_i;
            end else if (bus.req_we_i && !bus.mem_busy_i) begin
              r_store_done <= 1'b1;
            end
          end
        end
        LOAD_WAIT: begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_load_ext;
          r_resp_rd    <= r_ld_rd;
        end
        STORE_WAIT: if (!bus.mem_busy_i) r_store_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o     = (r_state == IDLE);
  assign bus.resp_valid_o    = r_resp_valid;
  assign bus.resp_data_o     = r_resp_data;
  assign bus.resp_rd_o       = r_resp_rd;
  assign bus.store_done_o    = r_store_done;
  assign bus.misalign_o      = r_misalign;
  assign bus.misalign_addr_o = r_misalign_addr;
  assign bus.mem_addr_o      = w_mem_addr;
  assign bus.mem_re_o        = w_mem_re;
  assign bus.mem_we_o        = w_mem_we;
  assign bus.mem_wdata_o     = w_mem_wdata;
  assign bus.mem_wmask_o     = w_mem_wmask;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data_memory with 2-cycle RMW busy,
// shadow memory for expected data, and an ordered queue of expected pulses.
module tb_load_store_unit;
  localparam int unsigned DEPTH = 1024;
  localparam logic [2:0] K_RESP = 3'b100, K_ST = 3'b010, K_MIS = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if #(.depth_p(DEPTH)) bus();
  load_store_unit #(.depth_p(DEPTH)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // data_memory model: read data one cycle after re; partial writes busy at T and T+1, merged at end of T+1
  logic [31:0] mem [DEPTH];
  logic        rmw_pend;
  logic [9:0]  rmw_idx;
  logic [31:0] rmw_d;
  logic [3:0]  rmw_m;
  assign bus.mem_busy_i = (bus.mem_we_o && bus.mem_wmask_o != 4'hF) || rmw_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_pend        <= 1'b0;
      bus.mem_rdata_i <= '0;
    end else begin
      if (bus.mem_re_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[11:2]];
      if (bus.mem_we_o && bus.mem_wmask_o == 4'hF) mem[bus.mem_addr_o[11:2]] <= bus.mem_wdata_o;
      rmw_pend <= bus.mem_we_o && bus.mem_wmask_o != 4'hF;
      if (bus.mem_we_o) begin
        rmw_idx <= bus.mem_addr_o[11:2];
        rmw_d   <= bus.mem_wdata_o;
        rmw_m   <= bus.mem_wmask_o;
      end
      if (rmw_pend) begin
        for (int unsigned b = 0; b < 4; b++)
          if (rmw_m[b]) mem[rmw_idx][8*b +: 8] <= rmw_d[8*b +: 8];
      end
    end
  end

  // Pulse monitor: every pulse must match the head of the expectation queue
  exp_t mon_e;
  int   mon_np;
  always @(negedge clk) begin
    if (!rst) begin
      mon_np = int'(bus.resp_valid_o) + int'(bus.store_done_o) + int'(bus.misalign_o);
      if (mon_np != 0) begin
        chk("one_pulse", 32'(mon_np), 32'd1);
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'(mon_np), 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("pulse_kind", 32'({bus.resp_valid_o, bus.store_done_o, bus.misalign_o}), 32'(mon_e.kind));
          chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
          if (mon_e.kind == K_RESP) begin
            chk("resp_data", bus.resp_data_o, mon_e.data);
            chk("resp_rd", 32'(bus.resp_rd_o), 32'(mon_e.rd));
          end else if (mon_e.kind == K_MIS) begin
            chk("misalign_addr", bus.misalign_addr_o, mon_e.data);
          end
        end
      end
    end
  end

  logic [31:0] shadow [DEPTH];

  task automatic wait_idle();
    int n = 0;
    while (!(bus.req_ready_o && q.size() == 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(bus.req_ready_o && q.size() == 0), 32'd1);
    @(negedge clk);
  endtask

  // Issue one request at a negedge; checks the accept-cycle memory drive and ready timing
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    exp_t        e;
    logic        mis;
    logic [1:0]  off;
    logic [3:0]  em;
    logic [31:0] ew, word;
    off  = addr[1:0];
    mis  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && off != 2'b00);
    em   = 4'h0;
    ew   = 32'h0;
    e.rd = rd;
    chk("ready_before", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;  bus.req_we_i = we;  bus.req_size_i = sz;
    bus.req_unsigned_i = uns;  bus.req_addr_i = addr;  bus.req_wdata_i = wd;  bus.req_rd_i = rd;
    #1;
    if (mis) begin
      chk("mis_re", 32'(bus.mem_re_o), 32'd0);
      chk("mis_we", 32'(bus.mem_we_o), 32'd0);
      e.kind = K_MIS;  e.data = addr;  e.cyc = cyc + 1;
    end else if (we) begin
      case (sz)
        2'b00: begin
          ew = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
          case (off) 2'd0: em = 4'b0001; 2'd1: em = 4'b0010; 2'd2: em = 4'b0100; default: em = 4'b1000; endcase
        end
        2'b01: begin
          ew = {wd[15:0], wd[15:0]};
          em = off[1] ? 4'b1100 : 4'b0011;
        end
        default: begin ew = wd; em = 4'b1111; end
      endcase
      chk("st_we", 32'(bus.mem_we_o), 32'd1);
      chk("st_re", 32'(bus.mem_re_o), 32'd0);
      chk("st_mask", 32'(bus.mem_wmask_o), 32'(em));
      chk("st_wdata", bus.mem_wdata_o, ew);
      chk("st_addr", 32'(bus.mem_addr_o), 32'(addr[11:0]));
      for (int unsigned b = 0; b < 4; b++)
        if (em[b]) shadow[addr[11:2]][8*b +: 8] = ew[8*b +: 8];
      e.kind = K_ST;  e.data = 32'h0;  e.cyc = cyc + ((em == 4'hF) ? 1 : 3);
    end else begin
      word = shadow[addr[11:2]];
      case (sz)
        2'b00: e.data = uns ? {24'h0, word[8*off +: 8]} : {{24{word[8*off+7]}}, word[8*off +: 8]};
        2'b01: e.data = uns ? {16'h0, word[8*off +: 16]} : {{16{word[8*off+15]}}, word[8*off +: 16]};
        default: e.data = word;
      endcase
      chk("ld_re", 32'(bus.mem_re_o), 32'd1);
      chk("ld_we", 32'(bus.mem_we_o), 32'd0);
      chk("ld_addr", 32'(bus.mem_addr_o), 32'(addr[11:0]));
      e.kind = K_RESP;  e.cyc = cyc + 2;
    end
    q.push_back(e);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("ready_t1", 32'(bus.req_ready_o), 32'(mis || (we && em == 4'hF)));
    if (!mis && !we) begin
      @(negedge clk);
      chk("ready_t2_load", 32'(bus.req_ready_o), 32'd1);
    end else if (!mis && em != 4'hF) begin
      chk("rmw_addr_hold", 32'(bus.mem_addr_o), 32'(addr[11:0]));
      chk("rmw_we_low", 32'(bus.mem_we_o), 32'd0);
      @(negedge clk);
      chk("ready_t2_rmw", 32'(bus.req_ready_o), 32'd0);
      chk("rmw_addr_hold2", 32'(bus.mem_addr_o), 32'(addr[11:0]));
      @(negedge clk);
      chk("ready_t3_rmw", 32'(bus.req_ready_o), 32'd1);
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid_i = 1'b0;  bus.req_we_i = 1'b0;  bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0;  bus.req_addr_i = '0;  bus.req_wdata_i = '0;  bus.req_rd_i = '0;
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_pulses", 32'({bus.resp_valid_o, bus.store_done_o, bus.misalign_o}), 32'd0);
    chk("rst_mem_en", 32'({bus.mem_re_o, bus.mem_we_o}), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Known contents for the first 16 words
    for (int unsigned i = 0; i < 16; i++)
      do_req(1'b1, 2'b10, 1'b0, 32'(i * 4), 32'h0101_0101 * (i + 3), 5'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h000, 32'h8012_3456, 5'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h004, 32'h1122_3344, 5'd0);

    do_req(1'b0, 2'b00, 1'b0, 32'h003, 32'h0, 5'd7);           // lb  -> FFFFFF80
    do_req(1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 5'd3);           // lhu -> 00008012
    do_req(1'b0, 2'b01, 1'b0, 32'h000, 32'h0, 5'd4);           // lh  -> 00003456
    do_req(1'b1, 2'b00, 1'b0, 32'h005, 32'h0000_00A5, 5'd0);   // sb, RMW
    do_req(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 5'd9);           // lw  -> 1122A544
    do_req(1'b1, 2'b10, 1'b0, 32'h008, 32'hDEAD_BEEF, 5'd0);   // sw, full word
    do_req(1'b0, 2'b10, 1'b0, 32'h008, 32'h0, 5'd10);
    do_req(1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 5'd11);          // misaligned lh
    do_req(1'b1, 2'b10, 1'b0, 32'h006, 32'h1234_5678, 5'd0);   // misaligned sw
    do_req(1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 5'd12);          // illegal size
    do_req(1'b1, 2'b01, 1'b0, 32'h00A, 32'h0000_BEEF, 5'd0);   // sh upper half
    do_req(1'b0, 2'b01, 1'b1, 32'h00A, 32'h0, 5'd13);
    do_req(1'b0, 2'b00, 1'b0, 32'h00B, 32'h0, 5'd14);

    for (int unsigned i = 0; i < 24; i++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), $urandom, 5'($urandom_range(0, 31)));

    // Reset while a partial store sits in STORE_WAIT: dropped, no pulse
    bus.req_valid_i = 1'b1;  bus.req_we_i = 1'b1;  bus.req_size_i = 2'b00;
    bus.req_addr_i = 32'h020;  bus.req_wdata_i = 32'h77;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("sw_wait_ready", 32'(bus.req_ready_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst2_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst2_pulses", 32'({bus.resp_valid_o, bus.store_done_o, bus.misalign_o}), 32'd0);
    chk("rst2_mem", 32'({bus.mem_re_o, bus.mem_we_o, bus.mem_wmask_o}), 32'd0);
    chk("rst2_resp_data", bus.resp_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("post_rst_done", 32'(bus.store_done_o), 32'd0);
    repeat (3) @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 5'd15);
    do_req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 5'd16);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
